universal_shift_register_nbit: RTL and testbench

UNIVERSAL_SHIFT_REGISTER_NBIT -- requirements
Module: universal_shift_register_nbit

---
 rtl/universal_shift_register_nbit_pkg.sv | 31 +++
 rtl/universal_shift_register_nbit_if.sv | 30 +++
 rtl/universal_shift_register_nbit_counter.sv | 42 ++++
 rtl/universal_shift_register_nbit.sv | 87 ++++++++
 tb/tb_universal_shift_register_nbit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/universal_shift_register_nbit_pkg.sv
// Shared encodings for the universal shift register: operation select
// codes, serializer FSM states and the state register width.
package usr_pkg;

  // Operation select presented on modo while the FSM is idle.
  typedef enum logic [2:0] {
    MODO_HOLD   = 3'b000,
    MODO_LOAD   = 3'b001,
    MODO_SHL    = 3'b010,
    MODO_SHR    = 3'b011,
    MODO_ROL    = 3'b100,
    MODO_ROR    = 3'b101,
    MODO_SERIAL = 3'b110,
    MODO_RSVD   = 3'b111
  } modo_t;

  localparam int unsigned STATE_W = 2;

  // Serializer control states.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bit-counter width for a register of w bits (w >= 2).
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/universal_shift_register_nbit_if.sv
// Data/control bundle of the universal shift register. The master drives
// the operation select and data inputs; the slave (the register) drives
// the contents and serializer status.
interface universal_shift_register_nbit_if
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  logic [2:0]       modo;
  logic [WIDTH-1:0] In;
  logic             ser_in_l;
  logic             ser_in_r;
  logic [WIDTH-1:0] Q;
  logic             ser_out_l;
  logic             ser_out_r;
  logic             busy;
  logic             done;

  modport master (
    output modo, In, ser_in_l, ser_in_r,
    input  Q, ser_out_l, ser_out_r, busy, done
  );

  modport slave (
    input  modo, In, ser_in_l, ser_in_r,
    output Q, ser_out_l, ser_out_r, busy, done
  );

endinterface

// File: rtl/universal_shift_register_nbit_counter.sv
// Serializer bit counter: counts SHIFT edges and flags the final bit.
// Saturates at WIDTH-1 so it never wraps; clear has priority over enable.
module shift_bit_counter
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam int unsigned   CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_VAL = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last = (cnt_q == LAST_VAL);

  // Next count: clear on burst start, step on each shift edge until last.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !last) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/universal_shift_register_nbit.sv
// Universal N-bit shift register: hold, parallel load, logical shifts,
// rotates, and an LSB-first serializer burst controlled by a small FSM.
module universal_shift_register_nbit
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic                             clk,
  input logic                             reset,
  universal_shift_register_nbit_if.slave  bus
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             cnt_clear;
  logic             cnt_en;
  logic             cnt_last;

  shift_bit_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk    (clk),
    .rst    (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .last   (cnt_last)
  );

  // Next-state and next-contents decode; modo only matters in IDLE.
  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        case (modo_t'(bus.modo))
          MODO_LOAD:   q_d = bus.In;
          MODO_SHL:    q_d = {q_q[WIDTH-2:0], bus.ser_in_r};
          MODO_SHR:    q_d = {bus.ser_in_l, q_q[WIDTH-1:1]};
          MODO_ROL:    q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          MODO_ROR:    q_d = {q_q[0], q_q[WIDTH-1:1]};
          MODO_SERIAL: begin
            q_d       = bus.In;
            cnt_clear = 1'b1;
            state_d   = ST_SHIFT;
          end
          default:     q_d = q_q;
        endcase
      end
      ST_SHIFT: begin
        // Final shift happens on the same edge that leaves SHIFT.
        q_d    = {bus.ser_in_l, q_q[WIDTH-1:1]};
        cnt_en = 1'b1;
        if (cnt_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and contents registers; reset overrides any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
    end
  end

  assign bus.Q         = q_q;
  assign bus.ser_out_l = q_q[WIDTH-1];
  assign bus.ser_out_r = q_q[0];
  assign bus.busy      = (state_q == ST_SHIFT);
  assign bus.done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_universal_shift_register_nbit.sv
// Self-checking bench for universal_shift_register_nbit at WIDTH=8:
// directed vector table, serializer corner sequences, and randomized
// stimulus against a behavioural model.
module tb_universal_shift_register_nbit;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic reset;

  universal_shift_register_nbit_if #(.WIDTH(W)) bus ();

  universal_shift_register_nbit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic         rst;
    logic [2:0]   modo;
    logic [W-1:0] din;
    logic         sil;
    logic         sir;
    logic [W-1:0] exp_q;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_all(input string name, input logic [W-1:0] eq, input logic eb, input logic ed);
    check({name, ".Q"}, 32'(bus.Q), 32'(eq));
    check({name, ".busy"}, 32'(bus.busy), 32'(eb));
    check({name, ".done"}, 32'(bus.done), 32'(ed));
    check({name, ".ser_out_l"}, 32'(bus.ser_out_l), 32'(eq[W-1]));
    check({name, ".ser_out_r"}, 32'(bus.ser_out_r), 32'(eq[0]));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [2:0] m, input logic [W-1:0] d,
                       input logic sl, input logic sr);
    reset        = r;
    bus.modo     = m;
    bus.In       = d;
    bus.ser_in_l = sl;
    bus.ser_in_r = sr;
  endtask

  task automatic add(input logic r, input logic [2:0] m, input logic [W-1:0] d,
                     input logic sl, input logic sr, input logic [W-1:0] eq);
    vec_t v;
    v.rst = r; v.modo = m; v.din = d; v.sil = sl; v.sir = sr; v.exp_q = eq;
    vecs.push_back(v);
  endtask

  // Behavioural model: contents plus number of serializer bits still to go.
  logic [W-1:0] m_q;
  int           m_rem;
  logic         m_dn;

  task automatic model_edge(input logic r, input logic [2:0] m, input logic [W-1:0] d,
                            input logic sl, input logic sr);
    if (r) begin
      m_q = '0; m_rem = 0; m_dn = 1'b0;
    end else if (m_rem > 0) begin
      m_q   = (m_q >> 1) | (sl ? 8'h80 : 8'h00);
      m_rem = m_rem - 1;
      m_dn  = (m_rem == 0);
    end else if (m_dn) begin
      m_dn = 1'b0;
    end else begin
      case (m)
        3'd1: m_q = d;
        3'd2: m_q = (m_q << 1) | {7'd0, sr};
        3'd3: m_q = (m_q >> 1) | (sl ? 8'h80 : 8'h00);
        3'd4: m_q = (m_q << 1) | (m_q >> 7);
        3'd5: m_q = (m_q >> 1) | (m_q << 7);
        3'd6: begin m_q = d; m_rem = W; end
        default: ;
      endcase
    end
  endtask

  initial begin
    logic [W-1:0] pat;
    logic [W-1:0] expq;
    int           dn_cnt;

    drive(1'b1, 3'b000, 8'h00, 1'b0, 1'b0);

    // Directed table: reset, load/hold, shifts and rotates.
    add(1, 3'b000, 8'h00, 0, 0, 8'h00);
    add(0, 3'b001, 8'hA5, 0, 0, 8'hA5);
    add(1, 3'b000, 8'h00, 0, 0, 8'h00);
    add(0, 3'b001, 8'hFF, 0, 0, 8'hFF);
    add(1, 3'b001, 8'hFF, 0, 0, 8'h00);
    add(0, 3'b001, 8'h3C, 0, 0, 8'h3C);
    add(0, 3'b000, 8'hFF, 0, 0, 8'h3C);
    add(0, 3'b000, 8'h00, 1, 1, 8'h3C);
    add(0, 3'b000, 8'h12, 0, 1, 8'h3C);
    add(0, 3'b111, 8'hFF, 1, 1, 8'h3C);
    add(0, 3'b001, 8'h81, 0, 0, 8'h81);
    add(0, 3'b010, 8'h00, 0, 1, 8'h03);
    add(0, 3'b001, 8'h81, 0, 0, 8'h81);
    add(0, 3'b011, 8'h00, 0, 1, 8'h40);
    add(0, 3'b001, 8'h81, 0, 0, 8'h81);
    add(0, 3'b100, 8'h00, 0, 0, 8'h03);
    add(0, 3'b001, 8'h81, 0, 0, 8'h81);
    add(0, 3'b101, 8'h00, 0, 0, 8'hC0);
    add(0, 3'b011, 8'h00, 1, 0, 8'hE0);
    add(0, 3'b010, 8'h00, 1, 0, 8'hC0);
    add(1, 3'b110, 8'hFF, 1, 1, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].modo, vecs[i].din, vecs[i].sil, vecs[i].sir);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].exp_q, 1'b0, 1'b0);
    end

    // Serialize 0xB2, LSB first; load attempts during the burst are ignored.
    pat = 8'hB2;
    drive(0, 3'b110, pat, 0, 0);
    step();
    check_all("ser_k0", pat, 1'b1, 1'b0);
    drive(0, 3'b001, 8'hFF, 0, 0);
    for (int k = 1; k < W; k++) begin
      step();
      expq = pat >> k;
      check($sformatf("ser_bit%0d", k), 32'(bus.ser_out_r), 32'(pat[k]));
      check_all($sformatf("ser_k%0d", k), expq, 1'b1, 1'b0);
    end
    step();
    check_all("ser_done", 8'h00, 1'b0, 1'b1);
    step();
    check_all("ser_after_done", 8'h00, 1'b0, 1'b0);

    // Reset during the 4th SHIFT cycle aborts the burst with no done pulse.
    drive(0, 3'b110, pat, 1, 0);
    step();
    drive(0, 3'b000, 8'h00, 1, 0);
    step(); step(); step();
    check_all("mid_k3", 8'hF6, 1'b1, 1'b0);
    drive(1, 3'b000, 8'h00, 1, 0);
    step();
    check_all("mid_reset", 8'h00, 1'b0, 1'b0);
    drive(0, 3'b000, 8'h00, 1, 0);
    dn_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.done) dn_cnt++;
    end
    check("mid_no_done", 32'(dn_cnt), 32'd0);

    // Back-to-back bursts with modo held at serialize start.
    drive(0, 3'b110, 8'hB2, 0, 0);
    step();
    drive(0, 3'b110, 8'h5A, 0, 0);
    dn_cnt = 0;
    for (int s = 1; s <= 18; s++) begin
      step();
      if (bus.done) dn_cnt++;
      if (s == 8)  check_all("b2b_done1", 8'h00, 1'b0, 1'b1);
      if (s == 9)  check_all("b2b_gap", 8'h00, 1'b0, 1'b0);
      if (s == 10) begin
        check_all("b2b_start2", 8'h5A, 1'b1, 1'b0);
        drive(0, 3'b000, 8'h00, 0, 0);
      end
      if (s == 18) check_all("b2b_done2", 8'h00, 1'b0, 1'b1);
    end
    check("b2b_done_count", 32'(dn_cnt), 32'd2);

    // Randomized stimulus against the behavioural model.
    drive(1, 3'b000, 8'h00, 0, 0);
    model_edge(1, 3'b000, 8'h00, 0, 0);
    step();
    check_all("rnd_reset", m_q, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      logic         r;
      logic [2:0]   m;
      logic [W-1:0] d;
      logic         sl;
      logic         sr;
      r  = ($urandom_range(0, 29) == 0);
      m  = 3'($urandom_range(0, 7));
      d  = 8'($urandom);
      sl = 1'($urandom);
      sr = 1'($urandom);
      drive(r, m, d, sl, sr);
      model_edge(r, m, d, sl, sr);
      step();
      check_all($sformatf("rnd%0d", i), m_q, (m_rem > 0), m_dn);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
